// File: rtl/johnson_counter_param.sv
// johnson_counter_param
//   Parametrised shift-register counter. MODE 0 runs a twisted ring (Johnson,
//   period 2*WIDTH) and MODE 1 runs a one-hot ring (period WIDTH). Direction is
//   selectable at run time. The counter supports enable and parallel load,
//   decodes its sequence index, pulses on wrap, and recovers from illegal
//   patterns.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   en         advance one state per clock
//   dir        0 = forward (toward MSB), 1 = reverse
//   load       parallel load strobe (wins over en)
//   load_val   value written to out_bus on load
//   out_bus    registered counter state
//   state_idx  combinational sequence index of out_bus (0 when illegal)
//   wrap       registered one-cycle pulse after a step that crosses the boundary
//   illegal    combinational flag: out_bus is not a legal pattern for MODE
module johnson_counter_param #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MODE  = 0,
  parameter int unsigned IDXW  = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out_bus,
  output logic [IDXW-1:0]  state_idx,
  output logic             wrap,
  output logic             illegal
);

  localparam int unsigned CW       = $clog2(WIDTH + 1);
  localparam int unsigned XW       = IDXW + 1;
  localparam int unsigned LastIdx  = (MODE == 0) ? (2 * WIDTH - 1) : (WIDTH - 1);
  localparam logic        Twist    = (MODE == 0);
  localparam logic [WIDTH-1:0] RstVal = (MODE == 0) ? '0 : WIDTH'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  logic [CW-1:0]    ones;
  logic [CW-1:0]    edges;
  logic [IDXW-1:0]  pos;
  logic [XW-1:0]    down_idx;
  logic [IDXW-1:0]  idx_raw;
  logic             legal;
  logic             at_first;
  logic             at_last;
  logic [WIDTH-1:0] fwd_val;
  logic [WIDTH-1:0] rev_val;

  // Popcount, adjacent-bit transition count and set-bit position.
  always_comb begin
    ones  = '0;
    edges = '0;
    pos   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CW'(out_q[i]);
      if (out_q[i]) begin
        pos = IDXW'(i);
      end
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + CW'(out_q[i] ^ out_q[i+1]);
    end
  end

  // A Johnson pattern is a single run of ones anchored at one end, which is
  // exactly the set of words with at most one adjacent-bit transition.
  always_comb begin
    down_idx = XW'(2 * WIDTH) - XW'(ones);
    if (MODE == 0) begin
      legal = (edges <= CW'(1));
      if (out_q == '0) begin
        idx_raw = '0;
      end else if (out_q[0]) begin
        idx_raw = IDXW'(ones);
      end else begin
        idx_raw = down_idx[IDXW-1:0];
      end
    end else begin
      legal   = (ones == CW'(1));
      idx_raw = pos;
    end
  end

  assign illegal   = ~legal;
  assign state_idx = legal ? idx_raw : '0;
  assign at_first  = (state_idx == '0);
  assign at_last   = (state_idx == IDXW'(LastIdx));

  // Twisted ring inverts the bit fed back; one-hot ring rotates it unchanged.
  assign fwd_val = {out_q[WIDTH-2:0], out_q[WIDTH-1] ^ Twist};
  assign rev_val = {out_q[0] ^ Twist, out_q[WIDTH-1:1]};

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (en) begin
      if (illegal) begin
        // Recover without stepping; no wrap for this correction.
        out_d = RstVal;
      end else if (!dir) begin
        out_d  = fwd_val;
        wrap_d = at_last;
      end else begin
        out_d  = rev_val;
        wrap_d = at_first;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= RstVal;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out_bus = out_q;
  assign wrap    = wrap_q;

endmodule

// File: doc/johnson_counter_param.md
Name: johnson_counter_param

Overview:
Parametrised shift-register counter. It generalises the fixed 4-bit Johnson counter in three ways: configurable width, selectable twisted-ring (Johnson) or one-hot ring mode, and run-time direction control. It also adds enable, parallel load, a decoded state index, a wrap pulse, and self-correction out of illegal states. It is used as a low-glitch sequencer and phase generator wherever a decoded count is cheaper than a binary one.

Parameters:
WIDTH, 4, number of flip-flops in the ring; legal range is 2 to 16.
MODE, 0, 0 = Johnson (twisted ring, period 2*WIDTH); 1 = one-hot ring (period WIDTH).
IDXW, $clog2(2*WIDTH), width of state_idx; derived, not to be overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  reset, synchronous and active-high.
en  input  1  advance one state per clock while high.
dir  input  1  0 = forward (shift toward MSB), 1 = reverse.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value written to out_bus on load.
out_bus  output  WIDTH  counter state (registered).
state_idx  output  IDXW  sequence index of out_bus (combinational decode of the register).
wrap  output  1  one-cycle registered pulse on sequence wrap.
illegal  output  1  high while out_bus is not a legal pattern for MODE (combinational).

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high.
- Reset values:
  - MODE 0: out_bus = 0.
  - MODE 1: out_bus = 1 (bit 0 set).
  - Both modes: wrap = 0, state_idx = 0, illegal = 0.
- Priority per edge: rst > load > en. With en=0 and no load, the state holds. dir is sampled only when a step occurs.
- MODE 0 forward step: out <= {out[W-2:0], ~out[W-1]}. For W=4 the sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- MODE 0 reverse step: out <= {~out[0], out[W-1:1]}. This is the exact inverse sequence.
- MODE 1 forward step: rotate left (out[W-1] moves to bit 0).
- MODE 1 reverse step: rotate right.
- Legal patterns:
  - MODE 0: the 2*WIDTH Johnson patterns (contiguous ones anchored at LSB or MSB, including all-zero and all-one).
  - MODE 1: exactly one bit set.
- state_idx decode, MODE 0:
  - 0 if out == 0.
  - popcount(out) if out[0] == 1.
  - 2*WIDTH - popcount(out) otherwise.
- state_idx decode, MODE 1: the bit position of the set bit.
- state_idx is 0 whenever illegal = 1.
- Self-correction: if illegal = 1 and en = 1 with no load, the next state is the reset value (a step is not applied). wrap is not asserted for this correction.
- Load: out_bus <= load_val unconditionally, even if the value is illegal; illegal then reflects it. A load never asserts wrap.
- wrap timing: wrap is high for exactly the cycle after a step that crosses the sequence boundary, i.e. coincident with out_bus showing the new state.
  - Forward wrap: last index → 0.
  - Reverse wrap: 0 → last index.
  - Last index is 2*WIDTH-1 in MODE 0 and WIDTH-1 in MODE 1.
- Direction change: may occur on any cycle. The next step goes from the current state in the new direction, with no skipped or repeated state.
- Reset mid-operation: applies at the next edge regardless of en/load/dir. wrap clears in the same edge.
- Latency: one clock from en/load/rst to out_bus. state_idx and illegal follow out_bus combinationally.
- Period with en held high: MODE 0 wraps every 2*WIDTH cycles; MODE 1 every WIDTH cycles.

Test Plan:
- W=4, MODE 0: rst, then en=1, dir=0 for 9 clocks → out_bus 0,1,3,7,F,E,C,8,0; state_idx 0..7,0; wrap high only on the cycle showing 0 after 8.
- W=4, MODE 0, dir=1 from reset: out_bus 8,C,E,F,7,3,1,0; wrap on the first step (index 0 → 7), showing 8. Flip dir at out=E → next state C.
- W=5, MODE 1: rst gives out=00001. en=1, dir=0 for 5 clocks → 02,04,08,10,01; wrap on 01. Hold en=0 for 3 clocks → state unchanged, wrap=0.
- W=4, MODE 0: load with load_val=0101 → illegal=1, state_idx=0. Next en step → out=0000, illegal=0, wrap=0.
- Priority: rst=1, load=1, en=1 on the same edge → reset value. load=1 with en=1 → load_val, no step.
- Reset mid-sequence at out=1110 with en=1 → out=0000 on that edge. Counting resumes at 0001 on the next enabled edge.
